// File: rtl/rsa_modexp_ladder.sv
// Constant-time modular exponentiator (result = base^exp mod n) built on a Montgomery ladder
// with two bit-serial interleaved modular multiplier lanes; latency is independent of operands.
module rsa_modexp_ladder #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned EXP_BITS = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic [WIDTH-1:0]    base_i,
   input  logic [EXP_BITS-1:0] exp_i,
   input  logic [WIDTH-1:0]    n_i,
   output logic                busy_o,
   output logic [WIDTH-1:0]    result_o,
   output logic                done_o,
   output logic                err_o
);

   localparam int unsigned AW = WIDTH + 2;
   localparam int unsigned CW = $clog2(WIDTH);
   localparam int unsigned SW = $clog2(EXP_BITS);

   typedef enum logic [2:0] {StIdle, StReduce, StMul, StUpd, StDone} state_e;

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    base_q, base_d, n_q, n_d, r0_q, r0_d, r1_q, r1_d;
   logic [WIDTH-1:0]    result_q, result_d;
   logic [EXP_BITS-1:0] exp_q, exp_d;
   logic [AW-1:0]       acc0_q, acc0_d, acc1_q, acc1_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [SW-1:0]       step_q, step_d;
   logic                done_q, done_d, err_q, err_d;

   logic [WIDTH-1:0]    a0, b0, sel;
   logic [CW-1:0]       idx;
   logic [AW-1:0]       acc0_in, acc1_in, prod0, prod1, n_ext;
   logic                last_bit;

   // One MSB-first interleaved step; acc stays below n as long as b < n.
   function automatic logic [AW-1:0] mm_step(input logic [AW-1:0] acc, input logic abit,
                                             input logic [AW-1:0] b, input logic [AW-1:0] n);
      logic [AW-1:0] t;
      t = {acc[AW-2:0], 1'b0};
      if (t >= n) t = t - n;
      if (abit) t = t + b;
      if (t >= n) t = t - n;
      return t;
   endfunction

   always_comb begin
      idx      = CW'(WIDTH - 1) - cnt_q;
      last_bit = (cnt_q == CW'(WIDTH - 1));
      n_ext    = {2'b00, n_q};
      // During REDUCE, r0_q holds 1 mod n, so lane 0 yields base mod n.
      a0       = (state_q == StReduce) ? base_q : r0_q;
      b0       = (state_q == StReduce) ? r0_q : r1_q;
      sel      = exp_q[EXP_BITS-1] ? r1_q : r0_q;
      acc0_in  = (cnt_q == '0) ? '0 : acc0_q;
      acc1_in  = (cnt_q == '0) ? '0 : acc1_q;
      prod0    = mm_step(acc0_in, a0[idx], {2'b00, b0}, n_ext);
      prod1    = mm_step(acc1_in, sel[idx], {2'b00, sel}, n_ext);
   end

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      exp_d    = exp_q;
      n_d      = n_q;
      r0_d     = r0_q;
      r1_d     = r1_q;
      acc0_d   = acc0_q;
      acc1_d   = acc1_q;
      cnt_d    = cnt_q;
      step_d   = step_q;
      result_d = result_q;
      err_d    = err_q;
      done_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               base_d  = base_i;
               exp_d   = exp_i;
               n_d     = n_i;
               r0_d    = (n_i == WIDTH'(1)) ? '0 : WIDTH'(1);
               r1_d    = '0;
               cnt_d   = '0;
               step_d  = '0;
               err_d   = 1'b0;
               state_d = StReduce;
            end
         end
         StReduce: begin
            acc0_d = prod0;
            cnt_d  = cnt_q + CW'(1);
            if (last_bit) begin
               cnt_d   = '0;
               r1_d    = prod0[WIDTH-1:0];
               state_d = StMul;
            end
         end
         StMul: begin
            acc0_d = prod0;
            acc1_d = prod1;
            cnt_d  = cnt_q + CW'(1);
            if (last_bit) begin
               cnt_d   = '0;
               state_d = StUpd;
            end
         end
         StUpd: begin
            if (exp_q[EXP_BITS-1]) begin
               r0_d = acc0_q[WIDTH-1:0];
               r1_d = acc1_q[WIDTH-1:0];
            end else begin
               r1_d = acc0_q[WIDTH-1:0];
               r0_d = acc1_q[WIDTH-1:0];
            end
            exp_d   = exp_q << 1;
            step_d  = step_q + SW'(1);
            state_d = (step_q == SW'(EXP_BITS - 1)) ? StDone : StMul;
         end
         StDone: begin
            done_d   = 1'b1;
            err_d    = (n_q == '0);
            result_d = (n_q == '0) ? '0 : r0_q;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         base_q   <= '0;
         exp_q    <= '0;
         n_q      <= '0;
         r0_q     <= '0;
         r1_q     <= '0;
         acc0_q   <= '0;
         acc1_q   <= '0;
         cnt_q    <= '0;
         step_q   <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         exp_q    <= exp_d;
         n_q      <= n_d;
         r0_q     <= r0_d;
         r1_q     <= r1_d;
         acc0_q   <= acc0_d;
         acc1_q   <= acc1_d;
         cnt_q    <= cnt_d;
         step_q   <= step_d;
         result_q <= result_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign busy_o   = (state_q != StIdle);
   assign result_o = result_q;
   assign done_o   = done_q;
   assign err_o    = err_q;

endmodule
